// File: rtl/npu_mem_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// npu_mem_sequencer_pkg
//   Shared types and constants for the NPU memory sequencer:
//     - phase_e : top-level inference phases
//     - step_e  : per-word copy steps (RD -> RWAIT -> WR)
//     - NPU core window map (base + per-memory start/depth, bytes)
//     - per-phase word counts derived from the window depths
//     - DataMem legal range and a helper that tests a byte span against it
// -----------------------------------------------------------------------------
package npu_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_LOAD_I,
    PH_LOAD_W,
    PH_LOAD_B,
    PH_KICK,
    PH_WAIT_NPU,
    PH_STORE_O,
    PH_DONE
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR
  } step_e;

  localparam int unsigned CNT_W = 16;

  // NPU core windows (byte offsets from NPU_BASE)
  localparam logic [31:0] NPU_BASE        = 32'h8200_0000;
  localparam logic [31:0] NPU_IMEM_START  = 32'h0000_0000;
  localparam logic [31:0] NPU_IMEM_DEPTH  = 32'h0000_3100;
  localparam logic [31:0] NPU_WMEM_START  = 32'h0000_3100;
  localparam logic [31:0] NPU_WMEM_DEPTH  = 32'h0000_3100;
  localparam logic [31:0] NPU_BMEM_START  = 32'h0000_6200;
  localparam logic [31:0] NPU_BMEM_DEPTH  = 32'h0000_0080;
  localparam logic [31:0] NPU_OMEM_START  = 32'h0000_6280;
  localparam logic [31:0] NPU_OMEM_DEPTH  = 32'h0000_2000;

  // The external image is I|W|B packed back to back, so its offsets match the
  // window start offsets above.
  localparam logic [31:0] IMG_BYTES  = NPU_IMEM_DEPTH + NPU_WMEM_DEPTH + NPU_BMEM_DEPTH;
  localparam logic [31:0] OMEM_BYTES = NPU_OMEM_DEPTH;

  localparam logic [CNT_W-1:0] WORDS_I = CNT_W'(NPU_IMEM_DEPTH >> 2);
  localparam logic [CNT_W-1:0] WORDS_W = CNT_W'(NPU_WMEM_DEPTH >> 2);
  localparam logic [CNT_W-1:0] WORDS_B = CNT_W'(NPU_BMEM_DEPTH >> 2);
  localparam logic [CNT_W-1:0] WORDS_O = CNT_W'(NPU_OMEM_DEPTH >> 2);

  // DataMem region, [lo, hi)
  localparam logic [31:0] DMEM_LO = 32'h0000_4000;
  localparam logic [31:0] DMEM_HI = 32'h01E5_7478;

  // True when [base, base+len) lies fully inside DataMem. Evaluated in 64 bits
  // so a span that wraps the address space can never look legal.
  function automatic logic in_dmem(input logic [63:0] base, input logic [63:0] len);
    return (base >= 64'(DMEM_LO)) && ((base + len) <= 64'(DMEM_HI));
  endfunction

endpackage

// File: rtl/npu_mem_sequencer_copy_engine.sv
// -----------------------------------------------------------------------------
// npu_mem_sequencer_copy_engine
//   Word-by-word copier with one read channel and one write channel.
//   On go it loads src/dst/nwords and runs RD -> RWAIT -> WR per word, with at
//   most one read outstanding. last pulses in the cycle the final wr_gnt is
//   seen; a go in that same cycle chains straight into the next block.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   go                    load src/dst/nwords and begin (engine idle or on last)
//   src, dst, nwords      byte addresses (+4 per word) and word count
//   last                  final word of the block accepted this cycle
//   rd_req/rd_addr        read request, held until rd_gnt
//   rd_gnt, rd_rvalid, rd_rdata   read accept and in-order read data
//   wr_req/wr_addr/wr_data        write request, held until wr_gnt
//   wr_gnt                write accept
// -----------------------------------------------------------------------------
module npu_mem_sequencer_copy_engine
  import npu_mem_sequencer_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [CNT_W-1:0] nwords,
  output logic             last,
  output logic             rd_req,
  output logic [AW-1:0]    rd_addr,
  input  logic             rd_gnt,
  input  logic             rd_rvalid,
  input  logic [DW-1:0]    rd_rdata,
  output logic             wr_req,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  input  logic             wr_gnt
);

  step_e            r_step;
  step_e            w_step_nxt;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [DW-1:0]    r_data;
  logic [CNT_W-1:0] r_left;
  logic             w_last;
  logic             w_wr_acc;

  assign w_wr_acc = (r_step == ST_WR) && wr_gnt;
  // r_left counts the word currently in flight, so 1 means final word
  assign w_last   = w_wr_acc && (r_left == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= ST_IDLE;
    end else begin
      r_step <= w_step_nxt;
    end
  end

  always_comb begin
    w_step_nxt = r_step;
    case (r_step)
      ST_IDLE:  w_step_nxt = ST_IDLE;
      ST_RD:    if (rd_gnt)    w_step_nxt = ST_RWAIT;
      // rd_rvalid only matters here; anywhere else it is dropped
      ST_RWAIT: if (rd_rvalid) w_step_nxt = ST_WR;
      ST_WR:    if (wr_gnt)    w_step_nxt = w_last ? ST_IDLE : ST_RD;
      default:  w_step_nxt = ST_IDLE;
    endcase
    if (go) w_step_nxt = ST_RD;
  end

  // Addresses, data and count are cleared on reset so every bus output is 0
  // straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_data <= '0;
      r_left <= '0;
    end else if (go) begin
      r_src  <= src;
      r_dst  <= dst;
      r_left <= nwords;
    end else begin
      if ((r_step == ST_RWAIT) && rd_rvalid) r_data <= rd_rdata;
      if (w_wr_acc) begin
        r_src  <= r_src + AW'(4);
        r_dst  <= r_dst + AW'(4);
        r_left <= r_left - CNT_W'(1);
      end
    end
  end

  assign last    = w_last;
  assign rd_req  = (r_step == ST_RD);
  assign rd_addr = r_src;
  assign wr_req  = (r_step == ST_WR);
  assign wr_addr = r_dst;
  assign wr_data = r_data;

endmodule

// File: rtl/npu_mem_sequencer.sv
// -----------------------------------------------------------------------------
// npu_mem_sequencer
//   DMA-style sequencer for one NPU inference: copies the I/W/B image from
//   external DataMem into the NPU core windows, pulses npu_start, waits for
//   npu_done, then copies OMEM back out to DataMem. Single bus master.
// Optional feature
//   NPU_SEQ_RANGE_CHECK_EN : when defined, a start whose source image or OMEM
//   destination leaves DataMem is rejected with a 1-cycle err pulse. When not
//   defined, err is tied 0 and every start in IDLE is accepted.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     1-cycle request, honoured only in IDLE
//   cfg_src_addr/cfg_dst_addr image source and OMEM destination (byte, low 2 bits ignored)
//   busy, done, err           status: busy until DONE exits, done/err pulses
//   npu_start, npu_done       NPU handshake
//   rd_req/rd_addr/rd_gnt/rd_rvalid/rd_rdata          read channel
//   wr_req/wr_addr/wr_data/wr_gnt                     write channel
// -----------------------------------------------------------------------------
module npu_mem_sequencer
  import npu_mem_sequencer_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_src_addr,
  input  logic [AW-1:0] cfg_dst_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          npu_start,
  input  logic          npu_done,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_gnt,
  input  logic          rd_rvalid,
  input  logic [DW-1:0] rd_rdata,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_gnt
);

  phase_e           r_phase;
  phase_e           w_phase_nxt;
  logic [AW-1:0]    r_cfg_src;
  logic [AW-1:0]    r_cfg_dst;
  logic [AW-1:0]    w_src_aln;
  logic [AW-1:0]    w_dst_aln;
  logic             w_start_ok;
  logic             w_start_acc;
  logic             w_go;
  logic [AW-1:0]    w_src;
  logic [AW-1:0]    w_dst;
  logic [CNT_W-1:0] w_nwords;
  logic             w_last;

  assign w_src_aln = cfg_src_addr & ~AW'(3);
  assign w_dst_aln = cfg_dst_addr & ~AW'(3);

`ifdef NPU_SEQ_RANGE_CHECK_EN
  logic r_err;

  assign w_start_ok = in_dmem(64'(w_src_aln), 64'(IMG_BYTES)) &&
                      in_dmem(64'(w_dst_aln), 64'(OMEM_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_phase == PH_IDLE) && start && !w_start_ok;
    end
  end

  assign err = r_err;
`else
  assign w_start_ok = 1'b1;
  assign err        = 1'b0;
`endif

  assign w_start_acc = (r_phase == PH_IDLE) && start && w_start_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IDLE;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // cfg is captured only on an accepted start; later changes are invisible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_src <= '0;
      r_cfg_dst <= '0;
    end else if (w_start_acc) begin
      r_cfg_src <= w_src_aln;
      r_cfg_dst <= w_dst_aln;
    end
  end

  // Phase sequencing. Copy blocks are chained by asserting go in the same
  // cycle as the engine's last, so the next rd_req follows with no gap. The
  // first block is launched from the live cfg inputs because the latch above
  // updates on the same edge.
  always_comb begin
    w_phase_nxt = r_phase;
    w_go        = 1'b0;
    w_src       = '0;
    w_dst       = '0;
    w_nwords    = '0;
    busy        = (r_phase != PH_IDLE);
    done        = 1'b0;
    npu_start   = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        if (w_start_acc) begin
          w_phase_nxt = PH_LOAD_I;
          w_go        = 1'b1;
          w_src       = w_src_aln + AW'(NPU_IMEM_START);
          w_dst       = AW'(NPU_BASE + NPU_IMEM_START);
          w_nwords    = WORDS_I;
        end
      end
      PH_LOAD_I: begin
        if (w_last) begin
          w_phase_nxt = PH_LOAD_W;
          w_go        = 1'b1;
          w_src       = r_cfg_src + AW'(NPU_WMEM_START);
          w_dst       = AW'(NPU_BASE + NPU_WMEM_START);
          w_nwords    = WORDS_W;
        end
      end
      PH_LOAD_W: begin
        if (w_last) begin
          w_phase_nxt = PH_LOAD_B;
          w_go        = 1'b1;
          w_src       = r_cfg_src + AW'(NPU_BMEM_START);
          w_dst       = AW'(NPU_BASE + NPU_BMEM_START);
          w_nwords    = WORDS_B;
        end
      end
      PH_LOAD_B: begin
        if (w_last) w_phase_nxt = PH_KICK;
      end
      PH_KICK: begin
        // npu_done seen here is deliberately not looked at
        npu_start   = 1'b1;
        w_phase_nxt = PH_WAIT_NPU;
      end
      PH_WAIT_NPU: begin
        if (npu_done) begin
          w_phase_nxt = PH_STORE_O;
          w_go        = 1'b1;
          w_src       = AW'(NPU_BASE + NPU_OMEM_START);
          w_dst       = r_cfg_dst;
          w_nwords    = WORDS_O;
        end
      end
      PH_STORE_O: begin
        if (w_last) w_phase_nxt = PH_DONE;
      end
      PH_DONE: begin
        done        = 1'b1;
        w_phase_nxt = PH_IDLE;
      end
      default: w_phase_nxt = PH_IDLE;
    endcase
  end

  npu_mem_sequencer_copy_engine #(
    .DW (DW),
    .AW (AW)
  ) u_copy (
    .clk       (clk),
    .rst       (rst),
    .go        (w_go),
    .src       (w_src),
    .dst       (w_dst),
    .nwords    (w_nwords),
    .last      (w_last),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt)
  );

endmodule

// File: tb/tb_npu_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_npu_mem_sequencer
//   Bus slave model (read data = hash of address), scoreboard of expected
//   writes, and directed phase/handshake checks. Honours
//   NPU_SEQ_RANGE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_npu_mem_sequencer;

  localparam int DW = 32;
  localparam int AW = 32;

`ifdef NPU_SEQ_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_src = '0;
  logic [AW-1:0] cfg_dst = '0;
  logic          busy, done, err, npu_start;
  logic          npu_done = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt = 1'b0;
  logic          rd_rvalid = 1'b0;
  logic [DW-1:0] rd_rdata = '0;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt = 1'b0;

  npu_mem_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_src_addr (cfg_src),
    .cfg_dst_addr (cfg_dst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .npu_start    (npu_start),
    .npu_done     (npu_done),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_rvalid    (rd_rvalid),
    .rd_rdata     (rd_rdata),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] sb[$];
  int          wr_cnt = 0;

  task automatic push_run(input logic [31:0] s, input logic [31:0] d);
    sb.delete();
    for (int i = 0; i < 3136; i++) sb.push_back({32'h8200_0000 + 32'(4*i), hash(s + 32'(4*i))});
    for (int i = 0; i < 3136; i++) sb.push_back({32'h8200_3100 + 32'(4*i), hash(s + 32'h3100 + 32'(4*i))});
    for (int i = 0; i < 32; i++)   sb.push_back({32'h8200_6200 + 32'(4*i), hash(s + 32'h6200 + 32'(4*i))});
    for (int i = 0; i < 2048; i++) sb.push_back({d + 32'(4*i), hash(32'h8200_6280 + 32'(4*i))});
  endtask

  // ---------------- bus slave ----------------
  bit          stall_en = 1'b0;
  bit          inj_en   = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_dly = 0;
  int          rd_wait = -1;
  int          wr_wait = -1;
  bit          rd_hold = 1'b0;
  logic [31:0] rd_hold_addr = '0;
  bit          wr_hold = 1'b0;
  logic [63:0] wr_hold_word = '0;

  function automatic int stall();
    if (!stall_en) return 0;
    if ($urandom_range(0, 5) != 0) return 0;
    return int'($urandom_range(1, 5));
  endfunction

  initial begin : slave
    logic [63:0] exp_w;
    forever begin
      @(negedge clk);
      rd_gnt    = 1'b0;
      wr_gnt    = 1'b0;
      rd_rvalid = 1'b0;
      rd_rdata  = '0;
      if (rst) begin
        pend = 1'b0; rd_wait = -1; wr_wait = -1; rd_hold = 1'b0; wr_hold = 1'b0;
      end else begin
        if (pend) begin
          if (pend_dly == 0) begin
            rd_rvalid = 1'b1;
            rd_rdata  = hash(pend_addr);
            pend      = 1'b0;
          end else begin
            pend_dly--;
          end
        end else if (inj_en && $urandom_range(0, 3) == 0) begin
          rd_rvalid = 1'b1;
          rd_rdata  = 32'hDEAD_BEEF ^ 32'(cyc);
        end

        if (rd_req) begin
          if (pend) chk_eq("rd_while_outstanding", 64'(rd_req), 64'd0);
          if (rd_hold) chk_eq("rd_addr_hold", 64'(rd_addr), 64'(rd_hold_addr));
          if (rd_wait < 0) rd_wait = stall();
          if (rd_wait == 0) begin
            rd_gnt    = 1'b1;
            rd_wait   = -1;
            rd_hold   = 1'b0;
            pend      = 1'b1;
            pend_addr = rd_addr;
            pend_dly  = stall();
          end else begin
            rd_wait--;
            rd_hold      = 1'b1;
            rd_hold_addr = rd_addr;
          end
        end else begin
          rd_hold = 1'b0;
        end

        if (wr_req) begin
          if (wr_hold) chk_eq("wr_hold", {wr_addr, wr_data}, wr_hold_word);
          if (wr_wait < 0) wr_wait = stall();
          if (wr_wait == 0) begin
            wr_gnt  = 1'b1;
            wr_wait = -1;
            wr_hold = 1'b0;
            wr_cnt++;
            if (sb.size() == 0) begin
              chk_eq("wr_unexpected", 64'(sb.size()), 64'd1);
            end else begin
              exp_w = sb.pop_front();
              chk_eq("wr", {wr_addr, wr_data}, exp_w);
            end
          end else begin
            wr_wait--;
            wr_hold      = 1'b1;
            wr_hold_word = {wr_addr, wr_data};
          end
        end else begin
          wr_hold = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence helpers ----------------
  int t0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d);
    cfg_src = s;
    cfg_dst = d;
    start   = 1'b1;
    t0      = cyc;
    tick();
    start   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  function automatic bit sig(input int w);
    case (w)
      0:       return npu_start;
      1:       return done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int lim, input string tag);
    int n;
    n = 0;
    while (!sig(w) && n < lim) begin
      tick();
      n++;
    end
    chk_eq(tag, 64'(sig(w)), 64'd1);
  endtask

  task automatic wait_writes(input int base, input int target, input int lim);
    int n;
    n = 0;
    while ((wr_cnt - base) < target && n < lim) begin
      tick();
      n++;
    end
    chk_eq("write_progress", 64'((wr_cnt - base) >= target), 64'd1);
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk_eq({pfx, "_busy"},      64'(busy),      64'd0);
    chk_eq({pfx, "_done"},      64'(done),      64'd0);
    chk_eq({pfx, "_err"},       64'(err),       64'd0);
    chk_eq({pfx, "_npu_start"}, 64'(npu_start), 64'd0);
    chk_eq({pfx, "_rd_req"},    64'(rd_req),    64'd0);
    chk_eq({pfx, "_wr_req"},    64'(wr_req),    64'd0);
    chk_eq({pfx, "_rd_addr"},   64'(rd_addr),   64'd0);
    chk_eq({pfx, "_wr_addr"},   64'(wr_addr),   64'd0);
    chk_eq({pfx, "_wr_data"},   64'(wr_data),   64'd0);
  endtask

  // One complete inference. side_stim adds a start-while-busy and an npu_done
  // during LOAD_W; kick_done also raises npu_done in the KICK cycle.
  task automatic full_run(input logic [31:0] s, input logic [31:0] d,
                          input bit side_stim, input bit kick_done);
    int base;
    push_run(s & ~32'h3, d & ~32'h3);
    base = wr_cnt;
    kick(s, d);
    chk_eq("busy_on_start", 64'(busy), 64'd1);
    chk_eq("first_rd_req",  64'(rd_req), 64'd1);
    chk_eq("first_rd_addr", 64'(rd_addr), 64'(s & ~32'h3));
    if (side_stim) begin
      repeat (20) tick();
      cfg_src = 32'h0; cfg_dst = 32'h0; start = 1'b1;
      tick();
      start = 1'b0;
      chk_eq("start_in_busy_err", 64'(err), 64'd0);
      wait_writes(base, 3200, 20000);
      npu_done = 1'b1;
      tick();
      npu_done = 1'b0;
    end
    wait_for(0, 60000, "npu_start_seen");
    if (!stall_en) chk_eq("kick_cycle", 64'(cyc - t0), 64'd18913);
    chk_eq("load_writes", 64'(wr_cnt - base), 64'd6304);
    if (kick_done) npu_done = 1'b1;
    tick();
    npu_done = 1'b0;
    chk_eq("npu_start_1cyc", 64'(npu_start), 64'd0);
    repeat (9) tick();
    chk_eq("wait_npu_idle_bus", 64'(rd_req), 64'd0);
    chk_eq("wait_npu_busy",     64'(busy),   64'd1);
    npu_done = 1'b1;
    tick();
    npu_done = 1'b0;
    chk_eq("store_rd_req",  64'(rd_req),  64'd1);
    chk_eq("store_rd_addr", 64'(rd_addr), 64'h8200_6280);
    wait_for(1, 60000, "done_seen");
    chk_eq("total_writes", 64'(wr_cnt - base), 64'd8352);
    chk_eq("sb_drained",   64'(sb.size()),     64'd0);
    chk_eq("busy_in_done", 64'(busy),          64'd1);
    tick();
    chk_eq("done_1cyc",    64'(done), 64'd0);
    chk_eq("busy_after",   64'(busy), 64'd0);
  endtask

  // Start attempt for the range-check cases; the design is reset afterwards.
  task automatic try_start(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input bit legal);
    bit acc;
    acc = legal || !RC;
    kick(s, d);
    chk_eq({tag, "_err"},    64'(err),    64'(!acc));
    chk_eq({tag, "_busy"},   64'(busy),   64'(acc));
    chk_eq({tag, "_rd_req"}, 64'(rd_req), 64'(acc));
    tick();
    chk_eq({tag, "_err_pulse"}, 64'(err),  64'd0);
    chk_eq({tag, "_busy2"},     64'(busy), 64'(acc));
    pulse_reset();
  endtask

  // ---------------- main ----------------
  initial begin : main
    int base;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("idle");

    // Zero-wait run with ignored start and ignored npu_done
    full_run(32'h0000_4000, 32'h0001_0000, 1'b1, 1'b0);

    // Reset during LOAD_W, then a fresh start from the top
    push_run(32'h0000_4000, 32'h0001_0000);
    base = wr_cnt;
    kick(32'h0000_4000, 32'h0001_0000);
    wait_writes(base, 3236, 20000);
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    sb.delete();
    push_run(32'h0000_8000, 32'h0002_0000);
    base = wr_cnt;
    kick(32'h0000_8000, 32'h0002_0000);
    chk_eq("restart_rd_addr", 64'(rd_addr), 64'h0000_8000);
    wait_writes(base, 4, 100);
    pulse_reset();

    // Random stalls, stray read data, unaligned cfg, npu_done during KICK
    stall_en = 1'b1;
    inj_en   = 1'b1;
    full_run(32'h0000_4003, 32'h0001_0001, 1'b0, 1'b1);
    stall_en = 1'b0;
    inj_en   = 1'b0;
    repeat (3) tick();

    // Range-check boundaries
    try_start("src_in_instmem", 32'h0000_0000, 32'h0001_0000, 1'b0);
    try_start("src_below_lo",   32'h0000_3FFC, 32'h0001_0000, 1'b0);
    try_start("dst_past_hi",    32'h0000_4000, 32'h01E5_6000, 1'b0);
    try_start("both_at_hi",     32'h01E5_11F8, 32'h01E5_5478, 1'b1);
    try_start("src_past_hi",    32'h01E5_11FC, 32'h0001_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
